// File: rtl/dma_bus_pkg.sv
// Shared types and constants for the DMA burst-bus slave and its SRAM.
// Field widths, the FSM state encoding and the default window placement live here.
package dma_bus_pkg;

    localparam int DATA_W  = 32;
    localparam int BE_W    = 4;
    localparam int BURST_W = 8;
    // One extra bit so a 256-beat burst can be counted without wrapping.
    localparam int CNT_W   = BURST_W + 1;

    localparam logic [31:0] DEFAULT_BASE_ADDRESS = 32'h5000_0000;
    localparam int          DEFAULT_ADDR_BITS    = 8;
    localparam int          DEFAULT_WAIT_STATES  = 0;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WAIT,
        READ_ADDR,
        READ,
        END,
        ERROR
    } state_e;

endpackage

// File: rtl/dma_slave_sram.sv
// Single-port synchronous SRAM backing the slave window: per-byte write
// enables and a registered read port with one cycle of latency.
module dma_slave_sram
    import dma_bus_pkg::*;
#(
    parameter int ADDR_BITS = DEFAULT_ADDR_BITS
) (
    input  logic                 clk_i,
    input  logic                 en_i,
    input  logic                 we_i,
    input  logic [BE_W-1:0]      be_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [DATA_W-1:0]    wdata_i,
    output logic [DATA_W-1:0]    rdata_o
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Contents survive reset, so neither the array nor the read register is reset.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (be_i[b]) begin
                        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dma_bus_slave.sv
// Burst-bus slave for the DMA controller: decodes a word-addressed SRAM window,
// serves single/burst reads and writes, inserts write wait states, flags bad bursts.
module dma_bus_slave
    import dma_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = DEFAULT_BASE_ADDRESS,
    parameter int          ADDR_BITS    = DEFAULT_ADDR_BITS,
    parameter int          WAIT_STATES  = DEFAULT_WAIT_STATES
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               begin_transaction_in,
    input  logic               end_transaction_in,
    input  logic               read_n_write_in,
    input  logic [DATA_W-1:0]  address_data_in,
    input  logic [BE_W-1:0]    byte_enables_in,
    input  logic [BURST_W-1:0] burst_size_in,
    input  logic               data_valid_in,
    output logic [DATA_W-1:0]  address_data_out,
    output logic               data_valid_out,
    output logic               end_transaction_out,
    output logic               busy_out,
    output logic               error_out
);

    localparam int TAG_LSB = ADDR_BITS + 2;
    localparam int WORDS   = 2 ** ADDR_BITS;

    state_e               state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BURST_W-1:0]   burst_q, burst_d;
    logic [BE_W-1:0]      be_q, be_d;
    logic [2:0]           wait_q, wait_d;

    logic                 vld_p1_q, vld_p1_d;
    logic                 vld_p2_q;
    logic [DATA_W-1:0]    data_p2_q;

    logic                 mem_en, mem_we;
    logic [DATA_W-1:0]    mem_rdata;
    logic                 selected, misaligned, overrun;
    logic [CNT_W-1:0]     total_beats;
    logic                 beat_ok, read_abort;

    assign selected    = begin_transaction_in &&
                         (address_data_in[31:TAG_LSB] == BASE_ADDRESS[31:TAG_LSB]);
    assign misaligned  = (address_data_in[1:0] != 2'b00);
    assign overrun     = (32'(address_data_in[ADDR_BITS+1:2]) + 32'(burst_size_in))
                         > 32'(WORDS - 1);
    assign total_beats = {1'b0, burst_q} + CNT_W'(1);
    assign beat_ok     = (cnt_q < total_beats);
    assign read_abort  = end_transaction_in && ((state_q == READ_ADDR) || (state_q == READ));

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        burst_d  = burst_q;
        be_d     = be_q;
        wait_d   = wait_q;
        vld_p1_d = 1'b0;
        mem_en   = 1'b0;
        mem_we   = 1'b0;

        case (state_q)
            IDLE: begin
                if (selected) begin
                    addr_d  = address_data_in[ADDR_BITS+1:2];
                    cnt_d   = '0;
                    burst_d = burst_size_in;
                    be_d    = byte_enables_in;
                    if (misaligned || overrun) begin
                        state_d = ERROR;
                    end else if (read_n_write_in) begin
                        state_d = READ_ADDR;
                    end else begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                if (data_valid_in) begin
                    if (beat_ok) begin
                        mem_en = 1'b1;
                        mem_we = 1'b1;
                        addr_d = addr_q + ADDR_BITS'(1);
                        cnt_d  = cnt_q + CNT_W'(1);
                        if (end_transaction_in) begin
                            state_d = IDLE;
                        end else if (WAIT_STATES > 0) begin
                            state_d = WAIT;
                            wait_d  = 3'(WAIT_STATES - 1);
                        end
                    end else begin
                        state_d = ERROR;
                    end
                end else if (end_transaction_in) begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (end_transaction_in) begin
                    state_d = IDLE;
                end else if (wait_q == 3'd0) begin
                    state_d = WRITE;
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end
            READ_ADDR: begin
                if (end_transaction_in) begin
                    state_d = IDLE;
                end else begin
                    mem_en   = 1'b1;
                    vld_p1_d = 1'b1;
                    addr_d   = addr_q + ADDR_BITS'(1);
                    cnt_d    = cnt_q + CNT_W'(1);
                    state_d  = READ;
                end
            end
            READ: begin
                if (end_transaction_in) begin
                    state_d = IDLE;
                end else if (beat_ok) begin
                    mem_en   = 1'b1;
                    vld_p1_d = 1'b1;
                    addr_d   = addr_q + ADDR_BITS'(1);
                    cnt_d    = cnt_q + CNT_W'(1);
                end else if (!vld_p1_q && vld_p2_q) begin
                    // Last beat is on the bus now; completion follows it directly.
                    state_d = END;
                end
            end
            END:     state_d = IDLE;
            ERROR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            burst_q <= '0;
            be_q    <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            burst_q <= burst_d;
            be_q    <= be_d;
            wait_q  <= wait_d;
        end
    end

    // Stage p1: SRAM read issued, data lands in the SRAM output register.
    dma_slave_sram #(
        .ADDR_BITS(ADDR_BITS)
    ) u_sram (
        .clk_i   (clock),
        .en_i    (mem_en),
        .we_i    (mem_we),
        .be_i    (be_q),
        .addr_i  (addr_q),
        .wdata_i (address_data_in),
        .rdata_o (mem_rdata)
    );

    // Stage p2: bus output register; zero whenever no beat is being driven.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            data_p2_q <= '0;
        end else if (read_abort) begin
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            data_p2_q <= '0;
        end else begin
            vld_p1_q  <= vld_p1_d;
            vld_p2_q  <= vld_p1_q;
            data_p2_q <= vld_p1_q ? mem_rdata : '0;
        end
    end

    assign address_data_out    = data_p2_q;
    assign data_valid_out      = vld_p2_q;
    assign end_transaction_out = (state_q == END);
    assign busy_out            = (state_q == WAIT);
    assign error_out           = (state_q == ERROR);

endmodule
